// File: rtl/decode_issue_ctrl_if.sv
// rtl/decode_issue_ctrl_if.sv - fetch/decode handshake bundle for the issue controller
// Ports: if_valid/if_inst/if_pc/if_ready (fetch side), id_valid/id_inst/id_pc/id_ready
// (decode side), flush (redirect), stall_cnt (load-use stall counter).
// master = environment driving fetch and decode, slave = the issue controller.
interface decode_issue_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             if_valid;
  logic [31:0]      if_inst;
  logic [31:0]      if_pc;
  logic             if_ready;
  logic             id_valid;
  logic [31:0]      id_inst;
  logic [31:0]      id_pc;
  logic             id_ready;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output if_valid, if_inst, if_pc, id_ready, flush,
    input  if_ready, id_valid, id_inst, id_pc, stall_cnt
  );

  modport slave (
    input  if_valid, if_inst, if_pc, id_ready, flush,
    output if_ready, id_valid, id_inst, id_pc, stall_cnt
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - 2-entry issue queue with load-use bubble and flush
// Ports: clk, rst (async active-high), bus (decode_issue_ctrl_if.slave):
//   fetch in  : if_valid, if_inst, if_pc / out if_ready
//   decode out: id_valid, id_inst, id_pc / in id_ready
//   flush in (squash queue), stall_cnt out (saturating load-use stall cycles)
module decode_issue_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  decode_issue_ctrl_if.slave bus
);

  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             load_pend;
  logic [4:0]       load_rd;
  logic [CNT_W-1:0] stall_q;

  logic [31:0] head;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        use_rs1;
  logic        use_rs2;
  logic        not_empty;
  logic        hazard;
  logic        enq;
  logic        deq;
  logic        issue_load;

  assign head      = mem_inst[rd_ptr];
  assign opcode    = head[6:0];
  assign funct3    = head[14:12];
  assign not_empty = (count != 2'd0);

  // Which source registers the head instruction actually reads.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
      7'b1110011: use_rs1 = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
      default: ;
    endcase
  end

  assign hazard = load_pend && not_empty &&
                  ((use_rs1 && (head[19:15] == load_rd)) ||
                   (use_rs2 && (head[24:20] == load_rd)));

  assign bus.if_ready  = (count != 2'(DEPTH));
  assign bus.id_valid  = not_empty && !hazard && !bus.flush;
  assign bus.id_inst   = head;
  assign bus.id_pc     = mem_pc[rd_ptr];
  assign bus.stall_cnt = stall_q;

  assign enq        = bus.if_valid && bus.if_ready && !bus.flush;
  assign deq        = bus.id_valid && bus.id_ready;
  assign issue_load = deq && (opcode == 7'b0000011) && (head[11:7] != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      load_pend <= 1'b0;
      load_rd   <= 5'd0;
      stall_q   <= '0;
    end else begin
      // Payload registers are written on enqueue only; flush leaves them alone.
      if (enq) begin
        mem_inst[wr_ptr] <= bus.if_inst;
        mem_pc[wr_ptr]   <= bus.if_pc;
      end

      if (bus.flush) begin
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        count     <= 2'd0;
        load_pend <= 1'b0;
      end else begin
        if (enq) wr_ptr <= ~wr_ptr;
        if (deq) rd_ptr <= ~rd_ptr;
        if (enq && !deq)      count <= count + 2'd1;
        else if (deq && !enq) count <= count - 2'd1;

        // A load issuing in the same cycle that retires the previous one re-arms.
        if (issue_load) begin
          load_pend <= 1'b1;
          load_rd   <= head[11:7];
        end else if (bus.id_ready) begin
          load_pend <= 1'b0;
        end

        if (hazard && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - directed and random checks of decode_issue_ctrl
module tb_decode_issue_ctrl;

  localparam int CNT_W = 16;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();
  decode_issue_ctrl #(.DEPTH(2), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  bit          lp;
  logic [4:0]  lrd;
  int          sc;
  int          total = 0;
  int          bad   = 0;
  int          idle;
  int          sc0;
  logic [31:0] pcn = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
    logic [6:0] op;
    bit r1, r2;
    op = inst[6:0];
    r1 = 0;
    r2 = 0;
    if (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011) begin r1 = 1; r2 = 1; end
    else if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) r1 = 1;
    else if (op == 7'b1110011 && inst[14:12] >= 3'd1 && inst[14:12] <= 3'd3) r1 = 1;
    return (r1 && inst[19:15] == r) || (r2 && inst[24:20] == r);
  endfunction

  task automatic model_reset();
    q.delete();
    lp  = 0;
    lrd = 5'd0;
    sc  = 0;
  endtask

  // Called at posedge+1. Drives one cycle, checks at negedge, advances the model.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic idr, input logic fl);
    bit hz, ev, enq, deq;
    ent_t h;
    bus.if_valid = v;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    bus.id_ready = idr;
    bus.flush    = fl;
    @(negedge clk);
    hz = lp && q.size() > 0 && reads_reg(q[0].inst, lrd);
    ev = q.size() > 0 && !hz && !fl;
    chk("if_ready", 32'(bus.if_ready), 32'(q.size() < 2));
    chk("id_valid", 32'(bus.id_valid), 32'(ev));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(sc));
    if (q.size() > 0) begin
      chk("id_inst", bus.id_inst, q[0].inst);
      chk("id_pc", bus.id_pc, q[0].pc);
      if (!bus.id_valid) idle++;
    end
    enq = v && q.size() < 2 && !fl;
    deq = ev && idr;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      lp = 0;
    end else begin
      if (hz && sc < SMAX) sc++;
      if (deq) begin
        h = q.pop_front();
        if (h.inst[6:0] == 7'b0000011 && h.inst[11:7] != 5'd0) begin
          lp  = 1;
          lrd = h.inst[11:7];
        end else if (idr) lp = 0;
      end else if (idr) lp = 0;
      if (enq) q.push_back('{inst, pc});
    end
  endtask

  task automatic push(input logic [31:0] inst, input logic idr);
    cycle(1'b1, inst, pcn, idr, 1'b0);
    pcn += 4;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0] a, b, d;
    logic [2:0] f3;
    logic [11:0] imm;
    a   = 5'($urandom_range(0, 3));
    b   = 5'($urandom_range(0, 3));
    d   = 5'($urandom_range(0, 3));
    f3  = 3'($urandom);
    imm = 12'($urandom);
    case ($urandom_range(0, 6))
      0, 1: return {imm, a, 3'b010, d, 7'b0000011};
      2:    return {7'b0, b, a, 3'b000, d, 7'b0110011};
      3:    return {imm, a, 3'b000, d, 7'b0010011};
      4:    return {imm, a, f3, d, 7'b1110011};
      5:    return {imm[6:0], b, a, 3'b000, imm[11:7], 7'b0100011};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.if_valid = 0;
    bus.if_inst  = 0;
    bus.if_pc    = 0;
    bus.id_ready = 0;
    bus.flush    = 0;
    model_reset();
    #2;
    chk("rst_if_ready", 32'(bus.if_ready), 32'd1);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_inst", bus.id_inst, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;

    // Fill with decode stalled, then drain in order.
    push(32'h00000013, 1'b0);
    push(32'h00100093, 1'b0);
    chk("fill_full", 32'(bus.if_ready), 32'd0);
    chk("fill_head", bus.id_pc, 32'h0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("fill_second", bus.id_pc, 32'h4);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);

    // Streaming addi at one per cycle.
    idle = 0;
    sc0  = sc;
    for (int i = 0; i < 8; i++) push(32'h00000013, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("stream_idle", 32'(idle), 32'd0);
    chk("stream_stall", 32'(bus.stall_cnt), 32'(sc0));

    // Load-use: one bubble; lui consumer and rd=x0 load: none.
    for (int k = 0; k < 3; k++) begin
      idle = 0;
      sc0  = int'(bus.stall_cnt);
      push(k == 2 ? 32'h0000A003 : 32'h0000A283, 1'b1);
      push(k == 1 ? 32'h000052B7 : 32'h00228333, 1'b1);
      cycle(1'b0, 0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 0, 1'b1, 1'b0);
      chk("lu_idle", 32'(idle), k == 0 ? 32'd1 : 32'd0);
      chk("lu_stall", 32'(int'(bus.stall_cnt) - sc0), k == 0 ? 32'd1 : 32'd0);
    end

    // Load-use with decode held off for 3 cycles.
    idle = 0;
    sc0  = int'(bus.stall_cnt);
    push(32'h0000A283, 1'b1);
    push(32'h00228333, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
    chk("ds_held", 32'(bus.id_valid), 32'd0);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("ds_release", 32'(bus.id_valid), 32'd1);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("ds_stall", 32'(int'(bus.stall_cnt) - sc0), 32'd4);
    chk("ds_idle", 32'(idle), 32'd4);

    // Flush with full queue and pending load.
    push(32'h0000A283, 1'b0);
    push(32'h00228333, 1'b1);
    push(32'h00228333, 1'b0);
    chk("fl_full", 32'(bus.if_ready), 32'd0);
    cycle(1'b1, 32'h00000013, 32'h100, 1'b0, 1'b1);
    chk("fl_ready", 32'(bus.if_ready), 32'd1);
    chk("fl_valid", 32'(bus.id_valid), 32'd0);
    push(32'h00228333, 1'b0);
    chk("fl_nobubble", 32'(bus.id_valid), 32'd1);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), rand_inst(), pcn, 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 31) == 0));
      pcn += 4;
    end
    cycle(1'b0, 0, 0, 1'b1, 1'b1);

    // Saturation: hazard held with decode stalled.
    push(32'h0000A283, 1'b1);
    push(32'h00228333, 1'b1);
    for (int i = 0; i < SMAX + 4; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0);
    chk("sat_max", 32'(bus.stall_cnt), 32'(SMAX));
    cycle(1'b0, 0, 0, 1'b1, 1'b0);
    chk("sat_hold", 32'(bus.stall_cnt), 32'(SMAX));

    // Asynchronous reset between edges.
    push(32'h00000013, 1'b0);
    #1;
    rst = 1;
    #1;
    chk("arst_if_ready", 32'(bus.if_ready), 32'd1);
    chk("arst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_id_inst", bus.id_inst, 32'd0);
    chk("arst_id_pc", bus.id_pc, 32'd0);
    chk("arst_stall", 32'(bus.stall_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    push(32'h00000013, 1'b1);
    cycle(1'b0, 0, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Instruction issue controller between instruction fetch and the decode/execute datapath (register read, immediate generation, ALU). It buffers fetched instructions in a 2-entry queue and hands them one at a time to decode under a valid/ready handshake. It inserts a single-cycle bubble for load-use hazards and discards queued instructions on a pipeline flush from a taken branch or jump. It also exposes a saturating hazard-stall counter for performance monitoring.

## Interface
- DEPTH, 2, queue entries (fixed at 2; pointer logic is sized for 2)
- CNT_W, 16, stall counter width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- if_valid  in  1  fetch offers an instruction
- if_inst  in  32  fetched instruction
- if_pc  in  32  PC of fetched instruction
- if_ready  out  1  queue can accept; equals (count < 2); depends only on registered state
- id_valid  out  1  head instruction is issuable this cycle
- id_inst  out  32  head instruction word
- id_pc  out  32  head PC
- id_ready  in  1  decode/execute accepts the instruction this cycle
- flush  in  1  taken branch/jump redirect; squash everything queued
- stall_cnt  out  CNT_W  cycles lost to load-use hazards

## Operation
- Enqueue when if_valid && if_ready && !flush. Issue (dequeue) when id_valid && id_ready.
- Queue: circular buffer with 1-bit rd/wr pointers and a 2-bit count (0..2). Enqueue and dequeue in the same cycle leave count unchanged. At count 2, if_ready=0, so there is no enqueue.
- id_inst and id_pc always show the head entry, even when id_valid=0. When count=0 they hold the last value written to that slot (0 after reset).
- Source usage, decoded from the head opcode inst[6:0]:
  - 0110011 (R), 0100011 (S), 1100011 (B): rs1 and rs2.
  - 0010011, 0000011 (LOAD), 1100111 (JALR): rs1 only.
  - 1110011 with funct3 in {001,010,011}: rs1 only.
  - 0110111, 0010111, 1101111, other funct3 of 1110011, and all other opcodes: none.
- Load tracker: on issue of an opcode 0000011 instruction with rd (inst[11:7]) != 0, set load_pend=1 and load_rd=rd.
  - load_pend clears on the first later cycle with id_ready=1, meaning the load has advanced out of EX.
  - A new load issued in that same cycle re-arms the tracker with the new rd (set wins).
- hazard = load_pend && count>0 && head uses a source register equal to load_rd.
- id_valid = (count>0) && !hazard && !flush.
- Flush, in the same cycle:
  - id_valid is forced to 0 and any enqueue is dropped.
  - On the next edge: count=0, pointers=0, load_pend=0.
  - Queue data registers are not cleared.
- stall_cnt increments by 1 on every cycle where count>0 && hazard && !flush. It saturates at 2^CNT_W-1 and is never cleared except by rst.

## Timing
- Reset values: count=0, pointers=0, load_pend=0, load_rd=0, stall_cnt=0, all queue entries 0. Outputs: if_ready=1, id_valid=0, id_inst=0, id_pc=0, stall_cnt=0.
- rst asserted mid-operation clears all state immediately (asynchronously). In-flight entries are lost.
- Latency: an instruction enqueued at edge N can issue in the cycle after edge N. Minimum fetch-to-issue latency is 1 cycle. With continuous if_valid and id_ready, sustained throughput is 1 instruction/cycle at count=1.
- Load-use penalty: exactly 1 bubble cycle when id_ready stays high. If id_ready is low after the load issues, the bubble persists until a cycle with id_ready=1 has passed.
- flush and rst share no priority with other events: flush overrides enqueue, issue and the stall increment in the same cycle.

## Test plan
- Reset/fill: after reset, check if_ready=1 and id_valid=0. With id_ready=0, push 0x00000013@pc 0x0 and 0x00100093@pc 0x4. Expect if_ready=0 after the second push. Release id_ready and expect issue of pc 0x0 then pc 0x4, in order.
- Streaming: with id_ready=1 and 8 back-to-back addi instructions, expect one issue per cycle, count steady at 1, and stall_cnt=0.
- Load-use: lw x5,0(x1) (0x0000A283) followed by add x6,x5,x2 (0x00228333). Expect exactly one id_valid=0 cycle between the two issues and stall_cnt=1.
  - Replace the second instruction with lui x5 (0x000052B7), or use rd=x0 in the load. Expect no bubble.
- Load-use with downstream stall: same lw/add pair, holding id_ready=0 for 3 cycles after the lw issues. Expect the add withheld until after the first id_ready=1 cycle. Expect stall_cnt to count every hazard cycle in which the queue is non-empty.
- Flush: with the queue full and load_pend=1, assert flush together with if_valid. Next cycle expect count=0, id_valid=0, if_ready=1 and load_pend=0. The next add x6,x5,x2 issues without a bubble.
- Saturation/async reset: preload stall_cnt near 0xFFFF (or set CNT_W=2) and force hazards; expect it to stick at the maximum. Assert rst mid-stream between edges and expect all outputs at reset values immediately.
